aes128_cozucu: RTL and testbench

Iterative AES-128 decryption core, the inverse of the team's pipelined encryptor. It accepts one 128-bit ciphertext block and a 128-bit cipher key over a valid/ready handshake. It expands the key forward to round key 10, then runs the ten inverse rounds one per clock while unwinding the key schedule in reverse. It sits on the receive side of the link and returns plaintext over a valid/ready output handshake.

---
 rtl/aes128_cozucu.sv | 270 +++++++++++++++++++++++++++
 tb/tb_aes128_cozucu.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_cozucu.sv
// Iterative AES-128 decryptor: forward key expansion, then ten inverse rounds.
// Optional key cache: AES_COZUCU_ANAHTAR_ONBELLEK_EN.
// Ports:
//   clk, rst (sync, active-low)
//   anahtar[127:0] key, sifre[127:0] ciphertext
//   g_gecerli valid in, hazir ready out
//   blok[127:0] plaintext, c_gecerli valid out
//   c_hazir downstream ready
module aes128_cozucu (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] anahtar,
    input  logic [127:0] sifre,
    input  logic         g_gecerli,
    output logic         hazir,
    output logic [127:0] blok,
    output logic         c_gecerli,
    input  logic         c_hazir
);

    typedef enum logic [1:0] {
        BOSTA,
        ANAHTAR,
        TUR,
        CIKIS
    } durum_t;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sb(input logic [7:0] x);
        logic [10:0] idx;
        idx = 11'd2047 - {x, 3'b000};
        return SBOX[idx -: 8];
    endfunction

    function automatic logic [7:0] inv_sb(input logic [7:0] x);
        logic [10:0] idx;
        idx = 11'd2047 - {x, 3'b000};
        return INV_SBOX[idx -: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] x, input logic [3:0] c);
        logic [7:0] x2, x4, x8;
        x2 = xt(x);
        x4 = xt(x2);
        x8 = xt(x4);
        return ({8{c[0]}} & x) ^ ({8{c[1]}} & x2)
             ^ ({8{c[2]}} & x4) ^ ({8{c[3]}} & x8);
    endfunction

    function automatic logic [31:0] inv_mix(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {
            gm(a0, 4'he) ^ gm(a1, 4'hb) ^ gm(a2, 4'hd) ^ gm(a3, 4'h9),
            gm(a0, 4'h9) ^ gm(a1, 4'he) ^ gm(a2, 4'hb) ^ gm(a3, 4'hd),
            gm(a0, 4'hd) ^ gm(a1, 4'h9) ^ gm(a2, 4'he) ^ gm(a3, 4'hb),
            gm(a0, 4'hb) ^ gm(a1, 4'hd) ^ gm(a2, 4'h9) ^ gm(a3, 4'he)
        };
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    durum_t       durum, durum_d;
    logic [3:0]   sayac;
    logic [127:0] anahtar_r, veri_r;
    logic         isabet;

    logic [31:0]  a0, a1, a2, a3;
    logic [31:0]  w3_sec, rot, kt;
    logic [7:0]   rc;
    logic [127:0] rk_ileri, rk_geri;
    logic [127:0] isr, isb_o, ark, imc, tur_sonuc;

`ifdef AES_COZUCU_ANAHTAR_ONBELLEK_EN
    logic         onb_gecerli;
    logic [127:0] onb_anahtar, onb_rk10;
    assign isabet = onb_gecerli && (anahtar == onb_anahtar);
`else
    assign isabet = 1'b0;
`endif

    // One SubWord serves both directions: the inverse step needs
    // w3 of the previous round key, which is w3 ^ w2 of the current one.
    assign {a0, a1, a2, a3} = anahtar_r;
    assign w3_sec = (durum == TUR) ? (a3 ^ a2) : a3;
    assign rc = rcon((durum == TUR) ? (4'd11 - sayac) : sayac);
    assign rot = {w3_sec[23:0], w3_sec[31:24]};
    assign kt = {sb(rot[31:24]), sb(rot[23:16]),
                 sb(rot[15:8]), sb(rot[7:0])} ^ {rc, 24'h0};

    assign rk_ileri[127:96] = a0 ^ kt;
    assign rk_ileri[95:64]  = a1 ^ rk_ileri[127:96];
    assign rk_ileri[63:32]  = a2 ^ rk_ileri[95:64];
    assign rk_ileri[31:0]   = a3 ^ rk_ileri[63:32];

    assign rk_geri = {a0 ^ kt, a1 ^ a0, a2 ^ a1, a3 ^ a2};

    // InvShiftRows: row r rotates right by r (column-major bytes)
    assign isr = {
        veri_r[127:120], veri_r[23:16], veri_r[47:40], veri_r[71:64],
        veri_r[95:88], veri_r[119:112], veri_r[15:8], veri_r[39:32],
        veri_r[63:56], veri_r[87:80], veri_r[111:104], veri_r[7:0],
        veri_r[31:24], veri_r[55:48], veri_r[79:72], veri_r[103:96]
    };

    for (genvar i = 0; i < 16; i++) begin : g_isb
        assign isb_o[127-8*i -: 8] = inv_sb(isr[127-8*i -: 8]);
    end

    assign ark = isb_o ^ rk_geri;

    for (genvar c = 0; c < 4; c++) begin : g_imc
        assign imc[127-32*c -: 32] = inv_mix(ark[127-32*c -: 32]);
    end

    assign tur_sonuc = (sayac == 4'd10) ? ark : imc;

    always_ff @(posedge clk) begin
        if (!rst) begin
            durum <= BOSTA;
        end else begin
            durum <= durum_d;
        end
    end

    always_comb begin
        durum_d   = durum;
        hazir     = 1'b0;
        c_gecerli = 1'b0;
        case (durum)
            BOSTA: begin
                hazir = 1'b1;
                if (g_gecerli) begin
                    durum_d = isabet ? TUR : ANAHTAR;
                end
            end
            ANAHTAR: begin
                if (sayac == 4'd10) begin
                    durum_d = TUR;
                end
            end
            TUR: begin
                if (sayac == 4'd10) begin
                    durum_d = CIKIS;
                end
            end
            CIKIS: begin
                c_gecerli = 1'b1;
                if (c_hazir) begin
                    durum_d = BOSTA;
                end
            end
            default: durum_d = BOSTA;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sayac     <= 4'd0;
            anahtar_r <= '0;
            veri_r    <= '0;
            blok      <= '0;
`ifdef AES_COZUCU_ANAHTAR_ONBELLEK_EN
            onb_gecerli <= 1'b0;
            onb_anahtar <= '0;
            onb_rk10    <= '0;
`endif
        end else begin
            case (durum)
                BOSTA: begin
                    if (g_gecerli) begin
                        sayac <= 4'd1;
`ifdef AES_COZUCU_ANAHTAR_ONBELLEK_EN
                        if (isabet) begin
                            anahtar_r <= onb_rk10;
                            veri_r    <= sifre ^ onb_rk10;
                        end else begin
                            anahtar_r   <= anahtar;
                            veri_r      <= sifre;
                            onb_gecerli <= 1'b0;
                            onb_anahtar <= anahtar;
                        end
`else
                        anahtar_r <= anahtar;
                        veri_r    <= sifre;
`endif
                    end
                end
                ANAHTAR: begin
                    anahtar_r <= rk_ileri;
                    sayac     <= sayac + 4'd1;
                    if (sayac == 4'd10) begin
                        veri_r <= veri_r ^ rk_ileri;
                        sayac  <= 4'd1;
`ifdef AES_COZUCU_ANAHTAR_ONBELLEK_EN
                        onb_gecerli <= 1'b1;
                        onb_rk10    <= rk_ileri;
`endif
                    end
                end
                TUR: begin
                    anahtar_r <= rk_geri;
                    veri_r    <= tur_sonuc;
                    sayac     <= sayac + 4'd1;
                    if (sayac == 4'd10) begin
                        blok  <= tur_sonuc;
                        sayac <= 4'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_cozucu.sv
// Bench for aes128_cozucu: FIPS vectors, backpressure, reset abort, random.
// Reference model is a straightforward FIPS-197 inverse cipher.
module tb_aes128_cozucu;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] anahtar, sifre, blok;
    logic         g_gecerli, hazir, c_gecerli, c_hazir;

    always #5 clk = ~clk;

    aes128_cozucu dut (
        .clk       (clk),
        .rst       (rst),
        .anahtar   (anahtar),
        .sifre     (sifre),
        .g_gecerli (g_gecerli),
        .hazir     (hazir),
        .blok      (blok),
        .c_gecerli (c_gecerli),
        .c_hazir   (c_hazir)
    );

`ifdef AES_COZUCU_ANAHTAR_ONBELLEK_EN
    localparam bit ONB = 1'b1;
`else
    localparam bit ONB = 1'b0;
`endif

    localparam logic [127:0] C1_K = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_P = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_K  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_C  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_P  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_RK = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    int checks = 0;
    int errors = 0;

    logic [7:0]   sb  [256];
    logic [7:0]   isb [256];
    bit           onb_ok;
    logic [127:0] onb_key;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from its definition: GF(2^8) inverse then the affine map
    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv, t, s;
        inv = 8'h00;
        if (x != 8'h00) begin
            inv = 8'h01;
            for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        end
        s = inv;
        t = inv;
        for (int n = 0; n < 4; n++) begin
            t = {t[6:0], t[7]};
            s = s ^ t;
        end
        return s ^ 8'h63;
    endfunction

    function automatic logic [10:0][127:0] expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        logic [10:0][127:0] rk;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]}
                  ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++)
            rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return rk;
    endfunction

    function automatic logic [127:0] decrypt(input logic [127:0] key,
                                             input logic [127:0] ct);
        logic [10:0][127:0] rk;
        logic [7:0] s [4][4];
        logic [7:0] t [4][4];
        logic [127:0] o;
        rk = expand(key);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = ct[127-8*(4*c+r) -: 8] ^ rk[10][127-8*(4*c+r) -: 8];
        for (int rd = 9; rd >= 0; rd--) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][c] = isb[s[r][(c-r+4)%4]] ^ rk[rd][127-8*(4*c+r) -: 8];
            if (rd > 0) begin
                for (int c = 0; c < 4; c++) begin
                    s[0][c] = gmul(t[0][c], 8'h0e) ^ gmul(t[1][c], 8'h0b)
                            ^ gmul(t[2][c], 8'h0d) ^ gmul(t[3][c], 8'h09);
                    s[1][c] = gmul(t[0][c], 8'h09) ^ gmul(t[1][c], 8'h0e)
                            ^ gmul(t[2][c], 8'h0b) ^ gmul(t[3][c], 8'h0d);
                    s[2][c] = gmul(t[0][c], 8'h0d) ^ gmul(t[1][c], 8'h09)
                            ^ gmul(t[2][c], 8'h0e) ^ gmul(t[3][c], 8'h0b);
                    s[3][c] = gmul(t[0][c], 8'h0b) ^ gmul(t[1][c], 8'h0d)
                            ^ gmul(t[2][c], 8'h09) ^ gmul(t[3][c], 8'h0e);
                end
            end else begin
                s = t;
            end
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[r][c];
        return o;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic xfer(input logic [127:0] k, input logic [127:0] ct,
                        input int hold, input bit erken, input string tag);
        logic [10:0][127:0] rk;
        logic [127:0] exp_pt;
        int exp_lat;
        int lat;
        rk = expand(k);
        exp_pt = decrypt(k, ct);
        exp_lat = (ONB && onb_ok && k == onb_key) ? 10 : 20;
        @(negedge clk);
        chk({tag, "_hazir_bos"}, hazir, 1);
        anahtar = k;
        sifre = ct;
        g_gecerli = 1'b1;
        c_hazir = erken;
        @(posedge clk);
        #1;
        g_gecerli = 1'b0;
        anahtar = rnd128();
        sifre = rnd128();
        chk({tag, "_hazir_dus"}, hazir, 0);
        if (exp_lat == 10) chk({tag, "_rk10"}, dut.anahtar_r, rk[10]);
        lat = 0;
        while (!c_gecerli && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 10 && exp_lat == 20)
                chk({tag, "_rk10"}, dut.anahtar_r, rk[10]);
        end
        chk({tag, "_gecikme"}, lat, exp_lat);
        chk({tag, "_blok"}, blok, exp_pt);
        onb_ok = 1'b1;
        onb_key = k;
        if (!erken) begin
            for (int i = 0; i < hold; i++) begin
                g_gecerli = 1'($urandom % 2);
                anahtar = rnd128();
                sifre = rnd128();
                @(posedge clk);
                #1;
                chk({tag, "_bp_gecerli"}, c_gecerli, 1);
                chk({tag, "_bp_blok"}, blok, exp_pt);
                chk({tag, "_bp_hazir"}, hazir, 0);
            end
            g_gecerli = 1'b0;
            c_hazir = 1'b1;
        end
        @(posedge clk);
        #1;
        c_hazir = 1'b0;
        chk({tag, "_tuk_hazir"}, hazir, 1);
        chk({tag, "_tuk_gecerli"}, c_gecerli, 0);
    endtask

    initial begin
        logic [10:0][127:0] rkb;
        logic [127:0] k, c;

        for (int i = 0; i < 256; i++) sb[i] = sbox_calc(i[7:0]);
        for (int i = 0; i < 256; i++) isb[sb[i]] = i[7:0];

        rst = 1'b0;
        g_gecerli = 1'b0;
        c_hazir = 1'b0;
        anahtar = '0;
        sifre = '0;
        onb_ok = 1'b0;
        onb_key = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_hazir", hazir, 1);
        chk("rst_gecerli", c_gecerli, 0);
        chk("rst_blok", blok, 0);
        rst = 1'b1;

        rkb = expand(B_K);
        chk("model_b_rk10", rkb[10], B_RK);
        chk("model_c1", decrypt(C1_K, C1_C), C1_P);
        chk("model_b", decrypt(B_K, B_C), B_P);

        xfer(C1_K, C1_C, 15, 1'b0, "c1");
        xfer(B_K, B_C, 2, 1'b0, "b1");
        xfer(B_K, B_C, 0, 1'b1, "b2");

        // abort during the fifth inverse round
        @(negedge clk);
        anahtar = C1_K;
        sifre = C1_C;
        g_gecerli = 1'b1;
        @(posedge clk);
        #1;
        g_gecerli = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        onb_ok = 1'b0;
        chk("abort_hazir", hazir, 1);
        chk("abort_gecerli", c_gecerli, 0);
        chk("abort_blok", blok, 0);
        @(posedge clk);
        #1;
        chk("abort_bosta", hazir, 1);

        xfer(C1_K, C1_C, 1, 1'b0, "c1_tekrar");
        xfer(C1_K, C1_C, 0, 1'b1, "c1_onb");
        xfer(B_K, B_C, 1, 1'b0, "b3");

        k = rnd128();
        for (int n = 0; n < 8; n++) begin
            if ($urandom % 3 != 0) k = rnd128();
            c = rnd128();
            xfer(k, c, int'($urandom % 4), 1'($urandom % 2), "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
